// File: rtl/e_mdu_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div as multi-cycle ops.
// Optional MDU_DIVZERO_FAST_EN: divide by zero finishes after a single busy cycle.
module e_mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  mdOp,
  input  logic [31:0] rsData,
  input  logic [31:0] rtData,
  output logic        startOp,
  output logic        busy,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic [31:0] HILOOut
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

`ifdef MDU_DIVZERO_FAST_EN
  localparam int DIVZ_CYCLES = 1;
`else
  localparam int DIVZ_CYCLES = DIV_CYCLES;
`endif

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic [31:0]        hiTmp_q, hiTmp_d, loTmp_q, loTmp_d;

  assign startOp = (mdOp == OP_MULT) || (mdOp == OP_MULTU) ||
                   (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
  assign busy    = busy_q;
  assign hiOut   = hi_q;
  assign loOut   = lo_q;
  assign HILOOut = (mdOp == OP_MFHI) ? hi_q :
                   (mdOp == OP_MFLO) ? lo_q : 32'd0;

  // Products: sign/zero extend to 64 bits; the low 64 bits of the product are exact.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{32{rsData[31]}}, rsData};
  assign b_sx   = {{32{rtData[31]}}, rtData};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, rsData} * {32'd0, rtData};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
  logic        div_zero;
  logic [31:0] b_safe, a_abs, b_abs, q_abs, r_abs, q_s, r_s, q_u, r_u;
  assign div_zero = (rtData == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : rtData;
  assign a_abs    = rsData[31] ? (32'd0 - rsData) : rsData;
  assign b_abs    = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign q_abs    = a_abs / b_abs;
  assign r_abs    = a_abs % b_abs;
  assign q_s      = (rsData[31] ^ b_safe[31]) ? (32'd0 - q_abs) : q_abs;
  assign r_s      = rsData[31] ? (32'd0 - r_abs) : r_abs;
  assign q_u      = rsData / b_safe;
  assign r_u      = rsData % b_safe;

  logic accept;
  assign accept = startOp && !busy_q && !Req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hiTmp_d = hiTmp_q;
    loTmp_d = loTmp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          busy_d = 1'b1;
          case (mdOp)
            OP_MULT: begin
              {hiTmp_d, loTmp_d} = prod_s;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MULT_RUN;
            end
            OP_MULTU: begin
              {hiTmp_d, loTmp_d} = prod_u;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = MULT_RUN;
            end
            default: begin
              // Divide by zero commits the current HI/LO back, i.e. no change.
              if (div_zero) begin
                hiTmp_d = hi_q;
                loTmp_d = lo_q;
                cnt_d   = CNT_W'(DIVZ_CYCLES);
              end else begin
                hiTmp_d = (mdOp == OP_DIV) ? r_s : r_u;
                loTmp_d = (mdOp == OP_DIV) ? q_s : q_u;
                cnt_d   = CNT_W'(DIV_CYCLES);
              end
              state_d = DIV_RUN;
            end
          endcase
        end else if (!Req && mdOp == OP_MTHI) begin
          hi_d = rsData;
        end else if (!Req && mdOp == OP_MTLO) begin
          lo_d = rsData;
        end
      end
      MULT_RUN, DIV_RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hiTmp_q;
          lo_d    = loTmp_q;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      hiTmp_q <= '0;
      loTmp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hiTmp_q <= hiTmp_d;
      loTmp_q <= loTmp_d;
    end
  end

endmodule

// File: tb/tb_e_mdu_unit.sv
// Directed bench for e_mdu_unit: scoreboard of expected HI/LO per started op, checked at commit.
module tb_e_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIVZERO_FAST_EN
  localparam int DZC = 1;
`else
  localparam int DZC = DC;
`endif

  logic        clk = 1'b0;
  logic        reset, Req;
  logic [3:0]  mdOp;
  logic [31:0] rsData, rtData;
  logic        startOp, busy;
  logic [31:0] hiOut, loOut, HILOOut;

  e_mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Req(Req), .mdOp(mdOp),
    .rsData(rsData), .rtData(rtData),
    .startOp(startOp), .busy(busy),
    .hiOut(hiOut), .loOut(loOut), .HILOOut(HILOOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start an op at the next edge, optionally present noise (a start with Req) while busy,
  // then count busy cycles and compare HI/LO against the scoreboard entry.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n, input logic [3:0] nop);
    exp_t e;
    int   cnt;
    mdOp = op; rsData = a; rtData = b; Req = 1'b0;
    #1 check({tag, ".startOp"}, 32'(startOp), 32'd1);
    sb.push_back('{hi: ehi, lo: elo, n: n});
    @(posedge clk);
    #1;
    mdOp = nop; rsData = ~a; rtData = b + 32'd1; Req = (nop != 4'd0);
    @(negedge clk);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    mdOp = 4'd0; Req = 1'b0;
    e = sb.pop_front();
    check({tag, ".busy_cycles"}, 32'(cnt), 32'(e.n));
    check({tag, ".hi"}, hiOut, e.hi);
    check({tag, ".lo"}, loOut, e.lo);
  endtask

  task automatic write_hilo(input logic [3:0] op, input logic [31:0] v, input logic rq);
    mdOp = op; rsData = v; Req = rq;
    @(negedge clk);
    mdOp = 4'd0; Req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; mdOp = 4'd0; rsData = '0; rtData = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.hi", hiOut, 32'd0);
    check("rst.lo", loOut, 32'd0);
    check("rst.hilo", HILOOut, 32'd0);
    check("rst.startOp", 32'(startOp), 32'd0);
    @(negedge clk);

    run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MC, 4'd0);
    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MC, 4'd0);
    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DC, 4'd0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, DC, 4'd0);

    write_hilo(4'd5, 32'h1234_5678, 1'b0);
    mdOp = 4'd7; #1;
    check("mfhi", HILOOut, 32'h1234_5678);
    mdOp = 4'd8; #1;
    check("mflo", HILOOut, 32'h8000_0000);
    mdOp = 4'd0;
    @(negedge clk);

    write_hilo(4'd6, 32'hDEAD_BEEF, 1'b1);
    check("mtlo_req.lo", loOut, 32'h8000_0000);

    mdOp = 4'd1; rsData = 32'd3; rtData = 32'd4; Req = 1'b1;
    @(negedge clk);
    mdOp = 4'd0; Req = 1'b0;
    check("mult_req.busy", 32'(busy), 32'd0);
    check("mult_req.lo", loOut, 32'h8000_0000);

    write_hilo(4'd5, 32'h0000_000A, 1'b0);
    write_hilo(4'd6, 32'h0000_000B, 1'b0);
    run_op("divu_z", 4'd4, 32'h0000_0005, 32'h0000_0000, 32'h0000_000A, 32'h0000_000B, DZC, 4'd0);
    run_op("div_z", 4'd3, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_000A, 32'h0000_000B, DZC, 4'd0);

    // A start presented (with Req) during the run must not disturb it.
    run_op("mult_noise", 4'd1, 32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFD6, MC, 4'd4);
    run_op("divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14, DC, 4'd2);

    // Reset during the third busy cycle abandons the op and clears HI/LO.
    mdOp = 4'd1; rsData = 32'd9; rtData = 32'd9;
    @(posedge clk); #1 mdOp = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_mid.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.busy", 32'(busy), 32'd0);
    check("rst_mid.hi", hiOut, 32'd0);
    check("rst_mid.lo", loOut, 32'd0);
    run_op("multu_after", 4'd2, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001, 32'h0003_0000, MC, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
